// File: rtl/ips2l_pcie_dma_bar_wr_router.sv
// ----------------------------------------------------------------------------
// ips2l_pcie_dma_bar_wr_router
//
// Steers upstream memory-write beats into one small FIFO per BAR.
// - Beats aimed at an unmapped BAR, or carrying no enabled bytes, are
//   accepted and discarded. They increment a saturating drop counter.
// - Each BAR drains its own FIFO through a valid/ready handshake.
// - There is no bypass path. A beat is visible on its BAR port at the
//   earliest one clock after it was accepted.
// - Beat order is preserved within a BAR. Nothing is guaranteed across BARs.
// ----------------------------------------------------------------------------
module ips2l_pcie_dma_bar_wr_router #(
  parameter int NUM_BARS   = 3,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  // upstream write beat
  input  logic                             i_wr_vld,
  output logic                             o_wr_rdy,
  input  logic [ADDR_WIDTH-1:0]            i_wr_addr,
  input  logic [DATA_WIDTH-1:0]            i_wr_data,
  input  logic [DATA_WIDTH/8-1:0]          i_wr_be,
  input  logic [1:0]                       i_wr_bar_hit,
  // per-BAR write ports, BAR k in slice k
  output logic [NUM_BARS-1:0]              o_bar_wr_en,
  input  logic [NUM_BARS-1:0]              i_bar_wr_rdy,
  output logic [NUM_BARS*ADDR_WIDTH-1:0]   o_bar_wr_addr,
  output logic [NUM_BARS*DATA_WIDTH-1:0]   o_bar_wr_data,
  output logic [NUM_BARS*DATA_WIDTH/8-1:0] o_bar_wr_be,
  // statistics / status
  input  logic                             i_cnt_clr,
  output logic [15:0]                      o_drop_cnt,
  output logic [NUM_BARS-1:0]              o_bar_fifo_full
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W    = $clog2(FIFO_DEPTH);
  localparam int PTR_W    = IDX_W + 1;
  localparam int ENT_W    = ADDR_WIDTH + DATA_WIDTH + BE_WIDTH;
  localparam logic [2:0] NUM_BARS_3B = 3'(NUM_BARS);

  // -------------------------------------------------------------------------
  // Full detection on wrap-extended pointers.
  // The low bits are equal but the pointers are a whole lap apart.
  // -------------------------------------------------------------------------
  function automatic logic ptr_full(input logic [PTR_W-1:0] wp,
                                    input logic [PTR_W-1:0] rp);
    return (wp[IDX_W-1:0] == rp[IDX_W-1:0]) && (wp[PTR_W-1] != rp[PTR_W-1]);
  endfunction

  logic                w_unmapped;
  logic                w_be_zero;
  logic                w_accept;
  logic                w_drop;
  logic [NUM_BARS-1:0] w_full;
  logic [NUM_BARS-1:0] w_empty;
  logic [3:0]          w_full_pad;
  logic [ENT_W-1:0]    w_in_entry;
  logic [15:0]         r_drop_cnt;

  assign w_unmapped = ({1'b0, i_wr_bar_hit} >= NUM_BARS_3B);
  assign w_be_zero  = (i_wr_be == {BE_WIDTH{1'b0}});
  assign w_accept   = i_wr_vld & o_wr_rdy;
  assign w_drop     = w_accept & (w_unmapped | w_be_zero);
  assign w_in_entry = {i_wr_addr, i_wr_data, i_wr_be};

  // Widen the per-BAR full flags to all four encodable BAR indices.
  // Indexing by i_wr_bar_hit then always stays in range.
  always_comb begin
    w_full_pad = 4'b0000;
    for (int i = 0; i < NUM_BARS; i++) begin
      w_full_pad[i] = w_full[i];
    end
  end

  // Upstream ready: unmapped beats always sink, mapped beats need FIFO room.
  always_comb begin
    o_wr_rdy = 1'b1;
    if (w_unmapped) begin
      o_wr_rdy = 1'b1;
    end else begin
      o_wr_rdy = ~w_full_pad[i_wr_bar_hit];
    end
  end

  // -------------------------------------------------------------------------
  // Per-BAR FIFO
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_BARS; k++) begin : g_bar
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] w_wptr_nxt;
    logic [PTR_W-1:0] w_rptr_nxt;
    logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [ENT_W-1:0] w_head;
    logic             w_push;
    logic             w_pop;
    logic             r_full;

    // A push can only happen when the FIFO is not full, because o_wr_rdy
    // already masked the handshake.
    assign w_push     = w_accept & ~w_drop & (i_wr_bar_hit == 2'(k));
    assign w_full[k]  = ptr_full(r_wptr, r_rptr);
    assign w_empty[k] = (r_wptr == r_rptr);
    assign w_pop      = ~w_empty[k] & i_bar_wr_rdy[k];

    // Next pointer values. They wrap naturally modulo 2*FIFO_DEPTH.
    always_comb begin
      w_wptr_nxt = r_wptr;
      w_rptr_nxt = r_rptr;
      if (w_push) begin
        w_wptr_nxt = r_wptr + PTR_W'(1);
      end else begin
        w_wptr_nxt = r_wptr;
      end
      if (w_pop) begin
        w_rptr_nxt = r_rptr + PTR_W'(1);
      end else begin
        w_rptr_nxt = r_rptr;
      end
    end

    // Pointer registers. Reset discards all buffered entries.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        r_wptr <= w_wptr_nxt;
        r_rptr <= w_rptr_nxt;
      end
    end

    // Full status register. It is loaded from the next pointers, so it
    // tracks the pointer state with no extra cycle of delay.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_full <= 1'b0;
      end else begin
        r_full <= ptr_full(w_wptr_nxt, w_rptr_nxt);
      end
    end

    // Entry storage. It is cleared on reset so payload outputs never carry X.
    // The write slot never aliases the head entry while data is pending.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          r_mem[i] <= '0;
        end
      end else if (w_push) begin
        r_mem[r_wptr[IDX_W-1:0]] <= w_in_entry;
      end else begin
        r_mem <= r_mem;
      end
    end

    assign w_head = r_mem[r_rptr[IDX_W-1:0]];

    assign o_bar_wr_en[k]                                = ~w_empty[k];
    assign o_bar_fifo_full[k]                            = r_full;
    assign o_bar_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]     = w_head[ENT_W-1 -: ADDR_WIDTH];
    assign o_bar_wr_data[k*DATA_WIDTH +: DATA_WIDTH]     = w_head[BE_WIDTH +: DATA_WIDTH];
    assign o_bar_wr_be[k*BE_WIDTH +: BE_WIDTH]           = w_head[BE_WIDTH-1:0];
  end

  // Saturating drop counter. A clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= 16'h0000;
    end else if (i_cnt_clr) begin
      r_drop_cnt <= 16'h0000;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'h0001;
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_ips2l_pcie_dma_bar_wr_router.sv
// ----------------------------------------------------------------------------
// Bench for ips2l_pcie_dma_bar_wr_router (NUM_BARS=3, FIFO_DEPTH=4).
// A per-BAR queue model predicts ready, full, enable and payload every cycle.
// A vector table and a few directed sequences drive the stimulus.
// ----------------------------------------------------------------------------
module tb_ips2l_pcie_dma_bar_wr_router;

  localparam int NB    = 3;
  localparam int AW    = 9;
  localparam int DW    = 128;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } exp_t;

  typedef struct {
    logic [1:0]    bar;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic          exp_rdy;
    logic [15:0]   exp_cnt;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_vld;
  logic             wr_rdy;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [BW-1:0]    wr_be;
  logic [1:0]       bar_hit;
  logic [NB-1:0]    bar_en;
  logic [NB-1:0]    bar_rdy;
  logic [NB*AW-1:0] bar_addr;
  logic [NB*DW-1:0] bar_data;
  logic [NB*BW-1:0] bar_be;
  logic             cnt_clr;
  logic [15:0]      drop_cnt;
  logic [NB-1:0]    fifo_full;

  exp_t        sbq [NB][$];
  logic [15:0] exp_drop;
  int          checks = 0;
  int          errors = 0;
  logic        last_acc;
  logic        last_rdy;
  logic [NB-1:0] last_en;
  int          stall_cnt = 0;
  vec_t        vt [8];

  ips2l_pcie_dma_bar_wr_router #(
    .NUM_BARS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .i_wr_vld(wr_vld), .o_wr_rdy(wr_rdy), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_wr_be(wr_be), .i_wr_bar_hit(bar_hit),
    .o_bar_wr_en(bar_en), .i_bar_wr_rdy(bar_rdy), .o_bar_wr_addr(bar_addr),
    .o_bar_wr_data(bar_data), .o_bar_wr_be(bar_be), .i_cnt_clr(cnt_clr),
    .o_drop_cnt(drop_cnt), .o_bar_fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_rdy();
    int idx;
    idx = int'(bar_hit);
    if (idx >= NB) return 1'b1;
    return sbq[idx].size() != DEPTH;
  endfunction

  // One clock. The task starts 1 time unit after a rising edge. It samples
  // and updates the model mid-cycle, then returns 1 unit after the next edge.
  task automatic cycle();
    logic acc, drp;
    int   idx;
    exp_t e;
    #3;
    if (rst) begin
      for (int k = 0; k < NB; k++) sbq[k].delete();
      exp_drop = 16'h0000;
    end
    last_rdy = wr_rdy;
    last_en  = bar_en;
    check("wr_rdy", DW'(wr_rdy), DW'(model_rdy()));
    check("drop_cnt", DW'(drop_cnt), DW'(exp_drop));
    for (int k = 0; k < NB; k++) begin
      check("bar_en", DW'(bar_en[k]), DW'(sbq[k].size() != 0));
      check("fifo_full", DW'(fifo_full[k]), DW'(sbq[k].size() == DEPTH));
      if (bar_en[k] && sbq[k].size() != 0) begin
        e = sbq[k][0];
        check("bar_addr", DW'(bar_addr[k*AW +: AW]), DW'(e.addr));
        check("bar_data", bar_data[k*DW +: DW], e.data);
        check("bar_be", DW'(bar_be[k*BW +: BW]), DW'(e.be));
        if (bar_rdy[k]) void'(sbq[k].pop_front());
      end
    end
    acc = wr_vld && wr_rdy && !rst;
    drp = acc && ((bar_hit >= 2'd3) || (wr_be == 16'h0000));
    last_acc = acc;
    if (acc && !drp) begin
      idx = int'(bar_hit);
      e.addr = wr_addr; e.data = wr_data; e.be = wr_be;
      sbq[idx].push_back(e);
    end
    if (cnt_clr) exp_drop = 16'h0000;
    else if (drp && exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'h0001;
    @(posedge clk); #1;
    if (stall_cnt > 0) begin
      stall_cnt--;
      if (stall_cnt == 0) bar_rdy[2] = 1'b1;
    end
  endtask

  // Hold a beat valid until it is accepted. The wait is bounded.
  task automatic send(input logic [1:0] bar, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic [BW-1:0] be);
    bar_hit = bar; wr_addr = addr; wr_data = data; wr_be = be; wr_vld = 1'b1;
    last_acc = 1'b0;
    for (int t = 0; t < 60; t++) begin
      cycle();
      if (last_acc) break;
    end
    checks++;
    if (!last_acc) begin
      errors++;
      $display("FAIL send_timeout: got no accept expected accept on bar %0d", bar);
    end
    wr_vld = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    vt[0] = '{bar: 2'd1, addr: 9'h010, data: 128'h1111_2222_3333_4444_5555_6666_7777_8888, be: 16'h000F, exp_rdy: 1'b1, exp_cnt: 16'd0};
    vt[1] = '{bar: 2'd0, addr: 9'h1FF, data: 128'hA5A5_A5A5_0000_FFFF_1234_5678_9ABC_DEF0, be: 16'hFFFF, exp_rdy: 1'b1, exp_cnt: 16'd0};
    vt[2] = '{bar: 2'd3, addr: 9'h000, data: 128'h0000_0000_0000_0000_0000_0000_0000_0001, be: 16'hFFFF, exp_rdy: 1'b1, exp_cnt: 16'd1};
    vt[3] = '{bar: 2'd2, addr: 9'h055, data: 128'h0000_0000_0000_0000_0000_0000_0000_0002, be: 16'h0000, exp_rdy: 1'b1, exp_cnt: 16'd2};
    vt[4] = '{bar: 2'd2, addr: 9'h123, data: 128'hCAFE_F00D_0000_0000_0000_0000_BEEF_0003, be: 16'h8001, exp_rdy: 1'b1, exp_cnt: 16'd2};
    vt[5] = '{bar: 2'd0, addr: 9'h0AA, data: 128'h0000_0000_0000_0000_0000_0000_0000_0004, be: 16'h0000, exp_rdy: 1'b1, exp_cnt: 16'd3};
    vt[6] = '{bar: 2'd1, addr: 9'h000, data: 128'h8000_0000_0000_0000_0000_0000_0000_0005, be: 16'h0001, exp_rdy: 1'b1, exp_cnt: 16'd3};
    vt[7] = '{bar: 2'd3, addr: 9'h1AB, data: 128'h0000_0000_0000_0000_0000_0000_0000_0006, be: 16'h0000, exp_rdy: 1'b1, exp_cnt: 16'd4};

    rst = 1'b1; wr_vld = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    bar_hit = 2'd0; bar_rdy = 3'b111; cnt_clr = 1'b0; exp_drop = 16'h0000;
    @(posedge clk); #1;
    repeat (3) cycle();
    check("reset_en", DW'(bar_en), DW'(3'b000));
    check("reset_full", DW'(fifo_full), DW'(3'b000));
    rst = 1'b0;
    cycle();

    // Single beat to BAR1: the enable is high for exactly one cycle,
    // starting one cycle after acceptance.
    bar_hit = 2'd1; wr_addr = 9'h010; wr_data = 128'hDEADBEEF; wr_be = 16'h000F; wr_vld = 1'b1;
    cycle();
    check("single_acc", DW'(last_acc), DW'(1'b1));
    check("single_en_same_cycle", DW'(last_en), DW'(3'b000));
    wr_vld = 1'b0;
    cycle();
    check("single_en_next", DW'(last_en), DW'(3'b010));
    cycle();
    check("single_en_after", DW'(last_en), DW'(3'b000));

    // Vector table: routed beats and drops, with free-running sinks.
    for (int i = 0; i < 8; i++) begin
      bar_hit = vt[i].bar; wr_addr = vt[i].addr; wr_data = vt[i].data;
      wr_be = vt[i].be; wr_vld = 1'b1;
      cycle();
      check("tbl_rdy", DW'(last_rdy), DW'(vt[i].exp_rdy));
      check("tbl_drop_cnt", DW'(drop_cnt), DW'(vt[i].exp_cnt));
    end
    wr_vld = 1'b0;
    repeat (4) cycle();

    // Backpressure on BAR0: four beats fill it and the fifth stalls.
    bar_rdy = 3'b110;
    for (int i = 0; i < 4; i++) send(2'd0, AW'(9'h040 + i), rnd128(), 16'hFFFF);
    bar_hit = 2'd0; wr_addr = 9'h044; wr_data = rnd128(); wr_be = 16'h00FF; wr_vld = 1'b1;
    cycle();
    check("bp_rdy_low", DW'(last_rdy), DW'(1'b0));
    check("bp_full", DW'(fifo_full[0]), DW'(1'b1));
    bar_rdy = 3'b111;
    send(2'd0, 9'h044, wr_data, 16'h00FF);
    repeat (8) cycle();

    // Interleaved BAR0/BAR2 with BAR2 stalled for 10 cycles.
    // 12 beats per BAR wrap the pointers several times.
    bar_rdy = 3'b011; stall_cnt = 10;
    for (int i = 0; i < 24; i++) send((i % 2 == 1) ? 2'd2 : 2'd0, AW'(i), rnd128(), BW'($urandom_range(1, 65535)));
    repeat (10) cycle();

    // Reset in the middle of a burst with three entries buffered.
    bar_rdy = 3'b000;
    for (int i = 0; i < 3; i++) send(2'd1, AW'(9'h100 + i), rnd128(), 16'hF0F0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_en", DW'(bar_en), DW'(3'b000));
    check("rst_async_full", DW'(fifo_full), DW'(3'b000));
    cycle();
    cycle();
    rst = 1'b0; bar_rdy = 3'b111;
    repeat (6) cycle();

    // Saturate the drop counter, then clear it alongside another drop.
    bar_hit = 2'd3; wr_be = 16'hFFFF; wr_vld = 1'b1;
    repeat (65537) cycle();
    check("sat_cnt", DW'(drop_cnt), DW'(16'hFFFF));
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0; wr_vld = 1'b0;
    check("clr_cnt", DW'(drop_cnt), DW'(16'h0000));
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
